// File: rtl/alu_issue_if.sv
// Handshake and datapath bundle for the ALU issue stage.
// Slave side is the stage itself; master side is its environment.
interface alu_issue_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [RW-1:0] in_rs1;
  logic [RW-1:0] in_rs2;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] in_imm;
  logic          in_wr_en;

  logic [DW-1:0] alu_x;
  logic [DW-1:0] alu_y;
  logic [2:0]    alu_control;
  logic [DW-1:0] alu_res;
  logic          alu_zero;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_res;
  logic [RW-1:0] out_rd;
  logic          out_wr_en;
  logic          out_br_taken;
  logic          out_illegal;

  modport master (
    output in_valid, in_opcode, in_rs1, in_rs2, in_rd,
    output in_a, in_b, in_imm, in_wr_en,
    output alu_res, alu_zero, out_ready,
    input  in_ready, alu_x, alu_y, alu_control,
    input  out_valid, out_res, out_rd, out_wr_en,
    input  out_br_taken, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_rs1, in_rs2, in_rd,
    input  in_a, in_b, in_imm, in_wr_en,
    input  alu_res, alu_zero, out_ready,
    output in_ready, alu_x, alu_y, alu_control,
    output out_valid, out_res, out_rd, out_wr_en,
    output out_br_taken, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-stage ALU issue wrapper: S1 registers ALU operands,
// S2 captures result, zero-based branch decision and writeback info.
module alu_issue_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave io
);

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [2:0]    ctrl;
    logic [RW-1:0] rd;
    logic          wr;
    logic          ill;
    logic          beq;
    logic          bne;
  } s1_t;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [RW-1:0] rd;
    logic          wr;
    logic          br;
    logic          ill;
  } s2_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  logic s1_adv, s2_adv;

  logic [2:0] dec_ctrl;
  logic       dec_imm;
  logic       dec_wr;
  logic       dec_ill;
  logic       dec_beq;
  logic       dec_bne;

  logic [DW-1:0] op_x, op_b, op_y;
  logic          br_taken;

  assign s2_adv = ~s2_valid_q | io.out_ready;
  assign s1_adv = ~s1_valid_q | s2_adv;

  // Opcode to ALU control, operand source and writeback qualifiers
  always_comb begin
    dec_ctrl = 3'b000;
    dec_imm  = 1'b0;
    dec_wr   = io.in_wr_en;
    dec_ill  = 1'b0;
    dec_beq  = 1'b0;
    dec_bne  = 1'b0;
    unique case (1'b1)
      ~io.in_opcode[3]: begin
        dec_ctrl = io.in_opcode[2:0];
      end
      io.in_opcode == 4'b1000: begin
        dec_imm = 1'b1;
      end
      io.in_opcode == 4'b1001: begin
        dec_imm = 1'b1;
        dec_wr  = 1'b0;
      end
      io.in_opcode == 4'b1010: begin
        dec_ctrl = 3'b001;
        dec_beq  = 1'b1;
        dec_wr   = 1'b0;
      end
      io.in_opcode == 4'b1011: begin
        dec_ctrl = 3'b001;
        dec_bne  = 1'b1;
        dec_wr   = 1'b0;
      end
      io.in_opcode[3:2] == 2'b11: begin
        dec_ill = 1'b1;
        dec_wr  = 1'b0;
      end
    endcase
    if (io.in_rd == '0) begin
      dec_wr = 1'b0;
    end
  end

  // Operand select: youngest in-flight writer wins, r0 is hardwired zero
  always_comb begin
    if (io.in_rs1 == '0) begin
      op_x = '0;
    end else if (s1_valid_q & s1_q.wr
                 & (s1_q.rd == io.in_rs1)) begin
      op_x = io.alu_res;
    end else if (s2_valid_q & s2_q.wr
                 & (s2_q.rd == io.in_rs1)) begin
      op_x = s2_q.res;
    end else begin
      op_x = io.in_a;
    end

    if (io.in_rs2 == '0) begin
      op_b = '0;
    end else if (s1_valid_q & s1_q.wr
                 & (s1_q.rd == io.in_rs2)) begin
      op_b = io.alu_res;
    end else if (s2_valid_q & s2_q.wr
                 & (s2_q.rd == io.in_rs2)) begin
      op_b = s2_q.res;
    end else begin
      op_b = io.in_b;
    end

    op_y = dec_imm ? io.in_imm : op_b;
  end

  // Branch outcome from the ALU zero flag of the instruction in S1
  always_comb begin
    br_taken = 1'b0;
    if (s1_q.beq) begin
      br_taken = io.alu_zero;
    end else if (s1_q.bne) begin
      br_taken = ~io.alu_zero;
    end
  end

  // Pipeline advance: S1 refill and S2 capture under backpressure
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s1_adv) begin
      s1_valid_d = io.in_valid;
      if (io.in_valid) begin
        s1_d.x    = op_x;
        s1_d.y    = op_y;
        s1_d.ctrl = dec_ctrl;
        s1_d.rd   = io.in_rd;
        s1_d.wr   = dec_wr;
        s1_d.ill  = dec_ill;
        s1_d.beq  = dec_beq;
        s1_d.bne  = dec_bne;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.res = io.alu_res;
        s2_d.rd  = s1_q.rd;
        s2_d.wr  = s1_q.wr;
        s2_d.br  = br_taken;
        s2_d.ill = s1_q.ill;
      end
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign io.in_ready     = s1_adv;
  assign io.alu_x        = s1_q.x;
  assign io.alu_y        = s1_q.y;
  assign io.alu_control  = s1_q.ctrl;
  assign io.out_valid    = s2_valid_q;
  assign io.out_res      = s2_q.res;
  assign io.out_rd       = s2_q.rd;
  assign io.out_wr_en    = s2_q.wr;
  assign io.out_br_taken = s2_q.br;
  assign io.out_illegal  = s2_q.ill;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-stage wrapper that sits directly upstream of the 16-bit ALU and captures what it produces. It accepts decoded instructions over a valid/ready handshake and maps the opcode to the 3-bit ALU control code. It selects and forwards operands, registers them into the combinational ALU, then registers the ALU result, zero flag and branch decision toward writeback. The block is a two-stage pipeline (S1 = ALU input register, S2 = result register) with full backpressure, one instruction per cycle.

## Interface
- `DW`, 16, datapath width (matches ALU)
- `RW`, 3, register index width (8 registers, r0 reads as zero)
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage can accept this cycle
- `in_opcode`  in  4  instruction opcode
- `in_rs1`, `in_rs2`, `in_rd`  in  RW each  source/destination indices
- `in_a`, `in_b`  in  DW each  register-file read data for rs1/rs2
- `in_imm`  in  DW  sign-extended immediate
- `in_wr_en`  in  1  instruction writes rd
- `alu_x`, `alu_y`  out  DW each  registered ALU operands
- `alu_control`  out  3  registered ALU operation code
- `alu_res`  in  DW  ALU result (combinational from alu_x/alu_y/alu_control)
- `alu_zero`  in  1  ALU zero flag
- `out_valid`  out  1  result present
- `out_ready`  in  1  writeback accepts
- `out_res`  out  DW  registered result
- `out_rd`  out  RW  destination index
- `out_wr_en`  out  1  write enable (0 for branches, stores, illegal, rd==0)
- `out_br_taken`  out  1  branch resolved taken
- `out_illegal`  out  1  opcode illegal

## Operation
- Opcode map: 0000–0111 -> alu_control = opcode[2:0] (ADD, SUB, NOT, LSL, LSR, AND, OR, SLT), y = B. 1000 ADDI -> 000, y = imm. 1001 ADDR (load/store address) -> 000, y = imm, wr_en forced 0. 1010 BEQ, 1011 BNE -> 001, y = B, wr_en 0. 1100–1111 -> 000, illegal = 1, wr_en 0.
- NOT ignores y; y still driven per map. Shifts pass all 16 bits of y to ALU unmodified.
- Forwarding per source (rs1, rs2), priority: S1 valid & S1 wr_en & S1 rd == rs -> alu_res; else S2 valid & S2 wr_en & S2 rd == rs -> out_res; else in_a/in_b. Index 0 never forwards and reads as 0 regardless of in_a/in_b.
- Advance rules: s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv (combinational, no loop through in_valid).
- S1 load on in_valid & in_ready; S1 holds (alu_x/y/control stable) when ~s1_adv. S1 valid clears when it advances with no new input.
- S2 load on s1_valid & s2_adv: out_res = alu_res; out_br_taken = BEQ ? alu_zero : BNE ? ~alu_zero : 0; rd, wr_en, illegal copied. S2 holds while out_valid & ~out_ready.
- out_wr_en additionally forced 0 when rd == 0.

## Timing
- Reset: in_ready 1 (combinational, S1 empty), alu_x 0, alu_y 0, alu_control 000, out_valid 0, out_res 0, out_rd 0, out_wr_en 0, out_br_taken 0, out_illegal 0; both valid bits 0.
- Latency: accepted at edge N -> alu_* valid after N -> out_valid after N+1 (2 cycles).
- Throughput 1/cycle with out_ready held 1; back-to-back dependent instructions need no bubble (S1 forwarding).
- out_ready low: S2 holds; S1 holds if full; in_ready drops only when both full. No instruction dropped or duplicated.
- Simultaneous S2 drain and S1 refill in the same edge allowed; forwarding uses pre-edge stage contents.
- rst asserted mid-stream: all in-flight instructions discarded at that edge; outputs take reset values next cycle.

## Test plan
- ADD r1 = 5 + 7 (in_a 5, in_b 7, rd 1), out_ready 1 -> alu_control 000 one cycle later; out_valid two cycles later, out_res 12, out_wr_en 1, out_rd 1.
- Dependent chain ADDI r2 = r0 + 3, then ADD r3 = r2 + r2 back-to-back with in_a/in_b stale 0 -> second result 6 (S1 forward); third ADD r4 = r2 + r0 one cycle later -> 3 (S2 forward).
- BEQ with A = B = 0x1234 -> out_br_taken 1, out_wr_en 0; BNE same operands -> 0; BNE 1 vs 2 -> 1.
- Backpressure: stream 4 instructions, out_ready low 3 cycles -> in_ready drops after 2 accepted, out_* stable while stalled, all 4 results emerge in order once out_ready returns.
- Opcode 1101 -> out_illegal 1, out_wr_en 0; ADD with rd 0 -> out_wr_en 0; LSL A = 1, B = 4 -> out_res 0x0010.
- Assert rst with both stages full -> next cycle out_valid 0, alu_control 000, in_ready 1.
